// File: rtl/regfile_pkg.sv
// Shared encodings for the register-file sequencer:
// opcodes, FSM states and ALU function codes.
package regfile_pkg;

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_CPYIN  = 3'b001;
  localparam logic [2:0] OP_CPYOUT = 3'b010;
  localparam logic [2:0] OP_ALU    = 3'b011;
  localparam logic [2:0] OP_COMP   = 3'b100;
  localparam logic [2:0] OP_HALT   = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_READ   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_sequencer_retire_counter.sv
// Wrapping retired-instruction counter with
// synchronous clear.
// Ports: clk, i_clr (sync clear), i_inc (count
// enable), o_cnt (W-bit count, wraps to 0).
module retire_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle sequencer driving register-file
// select, copy and ALU/compare strobes.
// Ports: clk, reset (sync, active high),
// instr_valid/instr/instr_ready handshake,
// reg_sel, cpyin, cpyout, alu_en, alu_fn, comp,
// halted (sticky), retired (CNT_W count).
module regfile_sequencer
  import regfile_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [7:0]       instr,
  output logic             instr_ready,
  output logic [2:0]       reg_sel,
  output logic             cpyin,
  output logic             cpyout,
  output logic             alu_en,
  output logic [1:0]       alu_fn,
  output logic             comp,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t     r_state;
  logic [2:0] r_op;
  logic [1:0] r_fn;
  logic [2:0] r_reg_sel;
  logic       r_ready;
  logic       r_cpyin;
  logic       r_cpyout;
  logic       r_alu_en;
  logic [1:0] r_alu_fn;
  logic       r_comp;
  logic       r_halted;

  logic w_dec_nop;
  logic w_dec_halt;
  logic w_dec_alu;
  logic w_dec_cpyin;
  logic w_dec_cpyout;
  logic w_dec_comp;
  logic w_retire;

  // Illegal opcodes fall into the NOP class.
  always_comb begin
    w_dec_nop    = 1'b0;
    w_dec_halt   = 1'b0;
    w_dec_alu    = 1'b0;
    w_dec_cpyin  = 1'b0;
    w_dec_cpyout = 1'b0;
    w_dec_comp   = 1'b0;
    unique case (1'b1)
      (r_op == OP_CPYIN):  w_dec_cpyin  = 1'b1;
      (r_op == OP_CPYOUT): w_dec_cpyout = 1'b1;
      (r_op == OP_ALU):    w_dec_alu    = 1'b1;
      (r_op == OP_COMP):   w_dec_comp   = 1'b1;
      (r_op == OP_HALT):   w_dec_halt   = 1'b1;
      default:             w_dec_nop    = 1'b1;
    endcase
  end

  // Retire on the edge leaving DECODE for
  // NOP/HALT, or leaving EXEC. Reset discards.
  assign w_retire = !reset && (
    (r_state == ST_EXEC) ||
    ((r_state == ST_DECODE) &&
     (w_dec_nop || w_dec_halt)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_NOP;
      r_fn      <= ALU_ADD;
      r_reg_sel <= '0;
      r_ready   <= 1'b1;
      r_cpyin   <= 1'b0;
      r_cpyout  <= 1'b0;
      r_alu_en  <= 1'b0;
      r_alu_fn  <= ALU_ADD;
      r_comp    <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_cpyin  <= 1'b0;
      r_cpyout <= 1'b0;
      r_alu_en <= 1'b0;
      r_comp   <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_op      <= instr[7:5];
            r_reg_sel <= instr[4:2];
            r_fn      <= instr[1:0];
            r_ready   <= 1'b0;
            r_state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_dec_nop) begin
            r_ready <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_dec_halt) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else if (w_dec_alu) begin
            r_state <= ST_READ;
          end else begin
            r_cpyin  <= w_dec_cpyin;
            r_cpyout <= w_dec_cpyout;
            r_comp   <= w_dec_comp;
            r_state  <= ST_EXEC;
          end
        end
        ST_READ: begin
          r_alu_en <= 1'b1;
          r_alu_fn <= r_fn;
          r_state  <= ST_EXEC;
        end
        ST_EXEC: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  retire_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .i_clr (reset),
    .i_inc (w_retire),
    .o_cnt (retired)
  );

  assign instr_ready = r_ready;
  assign reg_sel     = r_reg_sel;
  assign cpyin       = r_cpyin;
  assign cpyout      = r_cpyout;
  assign alu_en      = r_alu_en;
  assign alu_fn      = r_alu_fn;
  assign comp        = r_comp;
  assign halted      = r_halted;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer
// (CNT_W=4 so the counter wrap is reachable).
module tb_regfile_sequencer;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;
  logic [2:0] reg_sel;
  logic       cpyin;
  logic       cpyout;
  logic       alu_en;
  logic [1:0] alu_fn;
  logic       comp;
  logic       halted;
  logic [3:0] retired;
  logic [3:0] stb;

  int checks;
  int failures;

  regfile_sequencer #(
    .CNT_W (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .reg_sel     (reg_sel),
    .cpyin       (cpyin),
    .cpyout      (cpyout),
    .alu_en      (alu_en),
    .alu_fn      (alu_fn),
    .comp        (comp),
    .halted      (halted),
    .retired     (retired)
  );

  assign stb = {cpyin, cpyout, alu_en, comp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // advance one edge, sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot0", 16'($onehot0(stb)), 16'd1);
  endtask

  initial begin
    logic [7:0]  prog [4];
    logic [12:0] rdy_exp;
    logic [3:0]  stb_exp;
    int          k;
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 8'h00;
    step();
    step();
    reset = 1'b0;

    // reset state
    chk("rst_ready", 16'(instr_ready), 16'd1);
    chk("rst_stb", 16'(stb), 16'd0);
    chk("rst_ret", 16'(retired), 16'd0);
    chk("rst_halt", 16'(halted), 16'd0);
    chk("rst_sel", 16'(reg_sel), 16'd0);
    chk("rst_fn", 16'(alu_fn), 16'd0);

    // idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_stb", 16'(stb), 16'd0);
    end
    chk("idle_ready", 16'(instr_ready), 16'd1);
    chk("idle_ret", 16'(retired), 16'd0);

    // CPYOUT r3
    instr_valid = 1'b1;
    instr       = 8'b010_011_00;
    step();
    instr_valid = 1'b0;
    chk("co_dec_sel", 16'(reg_sel), 16'd3);
    chk("co_dec_stb", 16'(stb), 16'd0);
    chk("co_dec_rdy", 16'(instr_ready), 16'd0);
    step();
    chk("co_ex_stb", 16'(stb), 16'b0100);
    chk("co_ex_sel", 16'(reg_sel), 16'd3);
    chk("co_ex_ret", 16'(retired), 16'd0);
    step();
    chk("co_id_stb", 16'(stb), 16'd0);
    chk("co_id_ret", 16'(retired), 16'd1);
    chk("co_id_rdy", 16'(instr_ready), 16'd1);
    chk("co_id_sel", 16'(reg_sel), 16'd3);

    // ALU SUB r5
    instr_valid = 1'b1;
    instr       = 8'b011_101_01;
    step();
    instr_valid = 1'b0;
    chk("alu_dec_stb", 16'(stb), 16'd0);
    chk("alu_dec_sel", 16'(reg_sel), 16'd5);
    step();
    chk("alu_rd_stb", 16'(stb), 16'd0);
    chk("alu_rd_sel", 16'(reg_sel), 16'd5);
    chk("alu_rd_rdy", 16'(instr_ready), 16'd0);
    step();
    chk("alu_ex_stb", 16'(stb), 16'b0010);
    chk("alu_ex_fn", 16'(alu_fn), 16'd1);
    step();
    chk("alu_id_stb", 16'(stb), 16'd0);
    chk("alu_id_ret", 16'(retired), 16'd2);
    chk("alu_id_rdy", 16'(instr_ready), 16'd1);

    // stream with instr_valid held high
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s_rst_ret", 16'(retired), 16'd0);
    prog[0] = 8'b000_000_00;
    prog[1] = 8'b001_001_00;
    prog[2] = 8'b100_111_00;
    prog[3] = 8'b011_010_00;
    // bit c = expected instr_ready in cycle c
    rdy_exp = 13'b1_0001_0010_0101;
    k = 0;
    instr_valid = 1'b1;
    instr       = prog[0];
    for (int c = 0; c < 12; c++) begin
      stb_exp = 4'b0000;
      if (c == 4)  stb_exp = 4'b1000;
      if (c == 7)  stb_exp = 4'b0001;
      if (c == 11) stb_exp = 4'b0010;
      chk($sformatf("s_rdy_c%0d", c),
          16'(instr_ready), 16'(rdy_exp[c]));
      chk($sformatf("s_stb_c%0d", c),
          16'(stb), 16'(stb_exp));
      step();
      if (rdy_exp[c]) begin
        k++;
        if (k < 4) instr = prog[k];
        else instr_valid = 1'b0;
      end
    end
    chk("s_rdy_c12", 16'(instr_ready), 16'd1);
    chk("s_ret", 16'(retired), 16'd4);
    chk("s_alu_sel", 16'(reg_sel), 16'd2);

    // illegal opcode behaves as NOP
    instr_valid = 1'b1;
    instr       = 8'b111_110_11;
    step();
    instr_valid = 1'b0;
    chk("ill_dec_stb", 16'(stb), 16'd0);
    step();
    chk("ill_ret", 16'(retired), 16'd5);
    chk("ill_rdy", 16'(instr_ready), 16'd1);

    // HALT
    instr_valid = 1'b1;
    instr       = 8'b101_000_00;
    step();
    instr       = 8'b010_011_00;
    step();
    chk("h_halted", 16'(halted), 16'd1);
    chk("h_rdy", 16'(instr_ready), 16'd0);
    chk("h_ret", 16'(retired), 16'd6);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("h_ign_stb", 16'(stb), 16'd0);
      chk("h_ign_halt", 16'(halted), 16'd1);
      chk("h_ign_rdy", 16'(instr_ready), 16'd0);
    end
    chk("h_ign_ret", 16'(retired), 16'd6);
    instr_valid = 1'b0;
    reset       = 1'b1;
    step();
    reset = 1'b0;
    chk("h_rst_halt", 16'(halted), 16'd0);
    chk("h_rst_rdy", 16'(instr_ready), 16'd1);
    chk("h_rst_ret", 16'(retired), 16'd0);

    // reset during READ of an ALU instruction
    instr_valid = 1'b1;
    instr       = 8'b011_101_01;
    step();
    instr_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_stb", 16'(stb), 16'd0);
    chk("rr_rdy", 16'(instr_ready), 16'd1);
    chk("rr_sel", 16'(reg_sel), 16'd0);
    chk("rr_ret", 16'(retired), 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_idle_stb", 16'(stb), 16'd0);
    end
    chk("rr_idle_ret", 16'(retired), 16'd0);

    // counter wrap: 15 NOPs, then one more
    instr_valid = 1'b1;
    instr       = 8'h00;
    for (int i = 0; i < 30; i++) step();
    chk("w_ret15", 16'(retired), 16'd15);
    step();
    instr_valid = 1'b0;
    step();
    chk("w_ret0", 16'(retired), 16'd0);
    chk("w_rdy", 16'(instr_ready), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Multi-cycle control unit that sequences the 16-bit register file and result register (`res`) of the datapath. Accepts one 8-bit micro-instruction at a time over a valid/ready handshake. Walks each instruction through a fixed state sequence, driving register select, copy-in/copy-out and ALU/compare strobes. Sits between the instruction fetch stage and the register file/ALU pair.

## Interface
Parameters:
- `CNT_W`, 16, width of retired-instruction counter

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `instr_valid`  in  1  `instr` holds a new instruction
- `instr`  in  8  [7:5] opcode, [4:2] register index, [1:0] ALU function
- `instr_ready`  out  1  sequencer accepts `instr` this cycle
- `reg_sel`  out  3  register index to register file
- `cpyin`  out  1  one-cycle strobe: copy `res` into `reg[reg_sel]`
- `cpyout`  out  1  one-cycle strobe: copy `reg[reg_sel]` into `res`
- `alu_en`  out  1  one-cycle strobe: ALU result is written to `res`
- `alu_fn`  out  2  ALU function, valid while `alu_en`
- `comp`  out  1  one-cycle strobe: compare `res` with `reg[reg_sel]`
- `halted`  out  1  HALT retired; sticky until reset
- `retired`  out  CNT_W  count of retired instructions, including NOP

## Operation
- Opcodes: 000 NOP, 001 CPYIN, 010 CPYOUT, 011 ALU, 100 COMP, 101 HALT, 110/111 illegal.
- Illegal opcodes are handled as NOP: they retire and increment `retired`.
- States: IDLE, DECODE, READ, EXEC, HALT.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`: latch `instr` into an internal register, then go to DECODE.
- DECODE: drive `reg_sel` from the latched index. Next state by opcode:
  - NOP or illegal → retire, then IDLE.
  - HALT → retire, then HALT.
  - CPYIN, CPYOUT, COMP → EXEC.
  - ALU → READ.
- READ (ALU only): hold `reg_sel` for one cycle so the operand settles, then EXEC.
- EXEC:
  - Assert exactly one strobe: `cpyin`, `cpyout`, `alu_en` (with `alu_fn`) or `comp`.
  - Retire, then IDLE.
- HALT:
  - `halted`=1, `instr_ready`=0, all strobes 0.
  - Only `reset` leaves HALT.
- Retire means `retired` += 1 on that edge. Wraps modulo 2^CNT_W from all-ones to 0.
- `reg_sel` stays stable from DECODE through EXEC. In IDLE it holds its last value.
- At most one strobe is high in any cycle.

## Timing
- Reset values: state IDLE, `instr_ready`=1, `reg_sel`=0, `alu_fn`=0, all strobes 0, `halted`=0, `retired`=0.
- Handshake:
  - Transfer occurs on an edge where `instr_valid` and `instr_ready` are both 1.
  - `instr_ready` is a registered function of state: 1 only in IDLE.
- Latency from accept edge to strobe high:
  - CPYIN/CPYOUT/COMP: strobe high 2 cycles after accept (DECODE, then EXEC).
  - ALU: strobe high 3 cycles after accept.
- Throughput, in cycles per instruction including IDLE:
  - NOP: 2.
  - CPYIN/CPYOUT/COMP: 3.
  - ALU: 4.
- Back-to-back: when `instr_valid` is held high, the next instruction is accepted in the first IDLE cycle after retire.
- Reset asserted mid-instruction (any state):
  - Next edge returns to IDLE with reset values.
  - No strobe is asserted in the reset cycle's following edge.
  - The in-flight instruction is discarded and does not retire.
- `instr` is ignored while `instr_ready`=0. Changing `instr` during that time has no effect.

## Structure
- Shared package `regfile_pkg`:
  - opcode localparams `OP_NOP` … `OP_HALT`.
  - state enum encoding.
  - ALU function codes (00 ADD, 01 SUB, 10 AND, 11 OR).
- Single module; one registered FSM block plus a combinational strobe decode.
- Optional sub-module: `retire_counter` (CNT_W wrapping counter with synchronous clear).

## Test plan
- Reset then idle:
  - After reset, `instr_ready`=1, all strobes 0, `retired`=0.
  - Holding `instr_valid`=0 for 10 cycles changes nothing.
- CPYOUT r3 (`instr`=8'b010_011_00):
  - `reg_sel`=3 from the DECODE cycle on.
  - `cpyout` high exactly 2 cycles after accept, for 1 cycle.
  - `retired`=1; `instr_ready` returns high 3 cycles after accept.
- ALU SUB r5 (8'b011_101_01):
  - `alu_en`=1 with `alu_fn`=01 exactly 3 cycles after accept.
  - No other strobe is high at any time.
- Stream NOP, CPYIN r1, COMP r7, ALU r2 with `instr_valid` held high:
  - Accepts occur at cycles 0, 2, 5 and 8.
  - `retired`=4 after cycle 11.
- HALT (8'b101_000_00):
  - `halted`=1 and `instr_ready`=0 from then on.
  - Later valid instructions are ignored.
  - `reset` clears `halted` and returns `instr_ready`=1.
- Reset asserted in the READ state of an ALU instruction:
  - `alu_en` never pulses.
  - `retired` is unchanged at 0.
- Counter wrap:
  - Force `retired` to all-ones via CNT_W=4 and 15 NOPs.
  - The next NOP retires and `retired`=0.
